// File: rtl/obi_sb_slave.sv
// OBI system-bus slave backing a word-addressed RAM, used as the target of a
// debug-module system-bus master. Configurable grant delay and response latency.
module obi_sb_slave #(
  parameter logic [31:0] BaseAddr    = 32'h1C00_0000,
  parameter int unsigned MemWords    = 1024,
  parameter int unsigned GntWait     = 0,
  parameter int unsigned RespLatency = 1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        sb_req_i,
  input  logic [31:0] sb_addr_i,
  input  logic        sb_we_i,
  input  logic [31:0] sb_wdata_i,
  input  logic [3:0]  sb_be_i,
  output logic        sb_gnt_o,
  output logic        sb_rvalid_o,
  output logic [31:0] sb_rdata_o
);

  localparam int unsigned AW        = $clog2(MemWords);
  localparam logic [31:0] MEM_WORDS = 32'(MemWords);
  localparam logic [1:0]  WAIT_LAST = 2'(GntWait - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_GRANT = 2'd2
  } state_e;

  state_e                        state_r;
  logic [1:0]                    wait_cnt_r;
  logic                          gnt_s;
  logic [31:0]                   offset_s;
  logic [29:0]                   idx_s;
  logic [AW-1:0]                 mem_idx_s;
  logic                          in_range_s;
  logic [31:0]                   rd_s;
  logic                          unused_s;
  logic [31:0]                   mem_r [MemWords];
  logic [RespLatency-1:0]        vld_pipe_r;
  logic [RespLatency-1:0][31:0]  data_pipe_r;

  // Addresses below BaseAddr wrap to a huge index and fall out of range.
  assign offset_s   = sb_addr_i - BaseAddr;
  assign idx_s      = offset_s[31:2];
  assign mem_idx_s  = idx_s[AW-1:0];
  assign in_range_s = ({2'b00, idx_s} < MEM_WORDS);
  assign unused_s   = ^offset_s[1:0];

  // Grant decode: combinational pass-through without wait states, otherwise from GRANT state.
  always_comb begin
    gnt_s = 1'b0;
    if (!rst_ni) begin
      gnt_s = 1'b0;
    end else if (GntWait == 0) begin
      gnt_s = sb_req_i;
    end else if (state_r == ST_GRANT) begin
      gnt_s = sb_req_i;
    end else begin
      gnt_s = 1'b0;
    end
  end

  // Grant FSM: wait_cnt_r holds how many idle cycles have elapsed with the request held.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r    <= ST_IDLE;
      wait_cnt_r <= 2'd0;
    end else if (GntWait == 0) begin
      state_r    <= ST_IDLE;
      wait_cnt_r <= 2'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (sb_req_i) begin
            state_r    <= (GntWait == 1) ? ST_GRANT : ST_WAIT;
            wait_cnt_r <= 2'd1;
          end else begin
            state_r    <= ST_IDLE;
            wait_cnt_r <= 2'd0;
          end
        end
        ST_WAIT: begin
          if (!sb_req_i) begin
            state_r    <= ST_IDLE;
            wait_cnt_r <= 2'd0;
          end else if (wait_cnt_r == WAIT_LAST) begin
            state_r    <= ST_GRANT;
            wait_cnt_r <= 2'd0;
          end else begin
            state_r    <= ST_WAIT;
            wait_cnt_r <= wait_cnt_r + 2'd1;
          end
        end
        ST_GRANT: begin
          state_r    <= ST_IDLE;
          wait_cnt_r <= 2'd0;
        end
        default: begin
          state_r    <= ST_IDLE;
          wait_cnt_r <= 2'd0;
        end
      endcase
    end
  end

  // Byte-masked memory write at the grant edge; contents survive reset.
  always_ff @(posedge clk_i) begin
    if (gnt_s && sb_we_i && in_range_s) begin
      for (int b = 0; b < 4; b++) begin
        if (sb_be_i[b]) begin
          mem_r[mem_idx_s][8*b +: 8] <= sb_wdata_i[8*b +: 8];
        end
      end
    end
  end

  // Read data captured at the grant edge; zero for writes, idle and out-of-range.
  always_comb begin
    rd_s = 32'h0;
    if (gnt_s && !sb_we_i && in_range_s) begin
      rd_s = mem_r[mem_idx_s];
    end else begin
      rd_s = 32'h0;
    end
  end

  // Response pipeline: every grant enters stage 0 and emerges RespLatency cycles later.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_pipe_r  <= '0;
      data_pipe_r <= '0;
    end else begin
      vld_pipe_r[0]  <= gnt_s;
      data_pipe_r[0] <= rd_s;
      for (int i = 1; i < RespLatency; i++) begin
        vld_pipe_r[i]  <= vld_pipe_r[i-1];
        data_pipe_r[i] <= data_pipe_r[i-1];
      end
    end
  end

  assign sb_gnt_o    = gnt_s;
  assign sb_rvalid_o = vld_pipe_r[RespLatency-1];
  assign sb_rdata_o  = data_pipe_r[RespLatency-1];

endmodule

// File: tb/tb_obi_sb_slave.sv
// Bench for obi_sb_slave: three configurations, a directed vector table,
// a randomized run against a memory/response-queue model, and latency/reset corners.
module tb_obi_sb_slave;

  localparam logic [31:0] B   = 32'h1C00_0000;
  localparam int          RL0 = 1;

  logic        clk;
  logic        rst_ni;
  logic        req   [3];
  logic        we    [3];
  logic [31:0] addr  [3];
  logic [31:0] wdata [3];
  logic [3:0]  be    [3];
  logic        gnt   [3];
  logic        rv    [3];
  logic [31:0] rd    [3];

  int n_chk;
  int n_fail;
  int cyc_n;

  typedef struct {
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        exp_gnt;
    logic        exp_rv;
    logic [31:0] exp_rd;
  } vec_t;

  typedef struct {
    int          due;
    logic [31:0] data;
  } rsp_t;

  vec_t        tbl [$];
  rsp_t        q   [$];
  logic [31:0] mm  [32];

  obi_sb_slave u_dut0 (
    .clk_i(clk), .rst_ni(rst_ni), .sb_req_i(req[0]), .sb_addr_i(addr[0]),
    .sb_we_i(we[0]), .sb_wdata_i(wdata[0]), .sb_be_i(be[0]),
    .sb_gnt_o(gnt[0]), .sb_rvalid_o(rv[0]), .sb_rdata_o(rd[0])
  );

  obi_sb_slave #(.MemWords(16), .GntWait(2), .RespLatency(3)) u_dut1 (
    .clk_i(clk), .rst_ni(rst_ni), .sb_req_i(req[1]), .sb_addr_i(addr[1]),
    .sb_we_i(we[1]), .sb_wdata_i(wdata[1]), .sb_be_i(be[1]),
    .sb_gnt_o(gnt[1]), .sb_rvalid_o(rv[1]), .sb_rdata_o(rd[1])
  );

  obi_sb_slave #(.MemWords(16), .GntWait(0), .RespLatency(4)) u_dut2 (
    .clk_i(clk), .rst_ni(rst_ni), .sb_req_i(req[2]), .sb_addr_i(addr[2]),
    .sb_we_i(we[2]), .sb_wdata_i(wdata[2]), .sb_be_i(be[2]),
    .sb_gnt_o(gnt[2]), .sb_rvalid_o(rv[2]), .sb_rdata_o(rd[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic r, input logic w, input logic [31:0] a,
                              input logic [31:0] d, input logic [3:0] b,
                              input logic eg, input logic erv, input logic [31:0] erd);
    vec_t v;
    v.req = r; v.we = w; v.addr = a; v.wdata = d; v.be = b;
    v.exp_gnt = eg; v.exp_rv = erv; v.exp_rd = erd;
    return v;
  endfunction

  // One bus cycle on instance k with explicit expected outputs.
  task automatic cyc(input int k, input logic r, input logic w, input logic [31:0] a,
                     input logic [31:0] d, input logic [3:0] b, input logic eg,
                     input logic erv, input logic [31:0] erd, input string nm);
    req[k] = r; we[k] = w; addr[k] = a; wdata[k] = d; be[k] = b;
    @(negedge clk);
    chk({nm, "_gnt"}, 32'(gnt[k]), 32'(eg));
    chk({nm, "_rvalid"}, 32'(rv[k]), 32'(erv));
    chk({nm, "_rdata"}, rd[k], erd);
    @(posedge clk);
    #1;
  endtask

  // One randomized cycle on instance 0, checked against the memory/response model.
  task automatic rnd_cycle(input logic r, input logic w, input logic [31:0] a,
                           input logic [31:0] d, input logic [3:0] b);
    logic [31:0] off;
    logic [31:0] erd;
    logic [31:0] pd;
    logic        erv;
    logic        inr;
    int unsigned widx;
    rsp_t        e;
    req[0] = r; we[0] = w; addr[0] = a; wdata[0] = d; be[0] = b;
    @(negedge clk);
    if (q.size() > 0 && q[0].due == cyc_n) begin
      erv = 1'b1;
      erd = q[0].data;
      void'(q.pop_front());
    end else begin
      erv = 1'b0;
      erd = 32'h0;
    end
    chk("rnd_gnt", 32'(gnt[0]), 32'(r));
    chk("rnd_rvalid", 32'(rv[0]), 32'(erv));
    chk("rnd_rdata", rd[0], erd);
    if (r) begin
      off  = a - B;
      widx = off >> 2;
      inr  = (widx < 1024);
      pd   = 32'h0;
      if (w) begin
        if (inr) begin
          for (int i = 0; i < 4; i++) begin
            if (b[i]) mm[widx[4:0]][8*i +: 8] = d[8*i +: 8];
          end
        end
      end else if (inr) begin
        pd = mm[widx[4:0]];
      end
      e.due  = cyc_n + RL0;
      e.data = pd;
      q.push_back(e);
    end
    @(posedge clk);
    #1;
    cyc_n++;
  endtask

  function automatic logic [31:0] ldata(input int i);
    return 32'hA000_0000 + 32'(i) * 32'h0000_0111;
  endfunction

  initial begin
    n_chk  = 0;
    n_fail = 0;
    cyc_n  = 0;
    rst_ni = 1'b0;
    for (int k = 0; k < 3; k++) begin
      req[k] = 1'b0; we[k] = 1'b0; addr[k] = 32'h0; wdata[k] = 32'h0; be[k] = 4'h0;
    end

    // Reset state, including a request that must not be granted during reset
    repeat (3) @(posedge clk);
    req[0] = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) begin
      chk("rst_gnt", 32'(gnt[k]), 32'h0);
      chk("rst_rvalid", 32'(rv[k]), 32'h0);
      chk("rst_rdata", rd[k], 32'h0);
    end
    req[0] = 1'b0;
    @(negedge clk);
    rst_ni = 1'b1;
    @(posedge clk);
    #1;

    // Directed vectors: full/partial writes, out-of-range, be=0, unaligned address
    tbl.push_back(mk(1'b1, 1'b1, B,             32'hCAFE_F00D, 4'hF, 1'b1, 1'b0, 32'h0));
    tbl.push_back(mk(1'b1, 1'b1, B + 32'h10,    32'hDEAD_BEEF, 4'hF, 1'b1, 1'b1, 32'h0));
    tbl.push_back(mk(1'b1, 1'b0, B + 32'h10,    32'h0,         4'h0, 1'b1, 1'b1, 32'h0));
    tbl.push_back(mk(1'b0, 1'b0, 32'h0,         32'h0,         4'h0, 1'b0, 1'b1, 32'hDEAD_BEEF));
    tbl.push_back(mk(1'b1, 1'b1, B + 32'h10,    32'h1122_3344, 4'h5, 1'b1, 1'b0, 32'h0));
    tbl.push_back(mk(1'b1, 1'b0, B + 32'h10,    32'h0,         4'h0, 1'b1, 1'b1, 32'h0));
    tbl.push_back(mk(1'b0, 1'b0, 32'h0,         32'h0,         4'h0, 1'b0, 1'b1, 32'hDE22_BE44));
    tbl.push_back(mk(1'b1, 1'b0, B + 32'h1000,  32'h0,         4'hF, 1'b1, 1'b0, 32'h0));
    tbl.push_back(mk(1'b1, 1'b0, B - 32'h4,     32'h0,         4'hF, 1'b1, 1'b1, 32'h0));
    tbl.push_back(mk(1'b1, 1'b1, B + 32'h1000,  32'hFFFF_FFFF, 4'hF, 1'b1, 1'b1, 32'h0));
    tbl.push_back(mk(1'b1, 1'b1, B - 32'h4,     32'hFFFF_FFFF, 4'hF, 1'b1, 1'b1, 32'h0));
    tbl.push_back(mk(1'b1, 1'b1, B + 32'h10,    32'h0,         4'h0, 1'b1, 1'b1, 32'h0));
    tbl.push_back(mk(1'b1, 1'b0, B,             32'h0,         4'h0, 1'b1, 1'b1, 32'h0));
    tbl.push_back(mk(1'b1, 1'b0, B + 32'h13,    32'h0,         4'h0, 1'b1, 1'b1, 32'hCAFE_F00D));
    tbl.push_back(mk(1'b0, 1'b0, 32'h0,         32'h0,         4'h0, 1'b0, 1'b1, 32'hDE22_BE44));
    tbl.push_back(mk(1'b0, 1'b0, 32'h0,         32'h0,         4'h0, 1'b0, 1'b0, 32'h0));
    foreach (tbl[i]) begin
      cyc(0, tbl[i].req, tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].be,
          tbl[i].exp_gnt, tbl[i].exp_rv, tbl[i].exp_rd, $sformatf("tbl%0d", i));
    end

    // Randomized traffic on words 0..31 plus out-of-range addresses
    for (int i = 0; i < 32; i++) begin
      rnd_cycle(1'b1, 1'b1, B + 32'(4 * i), $urandom, 4'hF);
    end
    for (int i = 0; i < 400; i++) begin
      logic        r;
      logic        w;
      logic [31:0] a;
      int unsigned pick;
      r    = (($urandom % 4) != 0);
      w    = $urandom % 2;
      pick = $urandom % 10;
      if (pick < 8)       a = B + 32'(4 * ($urandom % 32)) + 32'($urandom % 4);
      else if (pick == 8) a = B + 32'h1000 + 32'(4 * ($urandom % 64));
      else                a = B - 32'h4 - 32'(4 * ($urandom % 64));
      rnd_cycle(r, w, a, $urandom, 4'($urandom % 16));
    end
    rnd_cycle(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    rnd_cycle(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);

    // GntWait=2, RespLatency=3: held write, abandoned requests, held read
    cyc(1, 1'b1, 1'b1, B, 32'h1234_5678, 4'hF, 1'b0, 1'b0, 32'h0, "w_hold1");
    cyc(1, 1'b1, 1'b1, B, 32'h1234_5678, 4'hF, 1'b0, 1'b0, 32'h0, "w_hold2");
    cyc(1, 1'b1, 1'b1, B, 32'h1234_5678, 4'hF, 1'b1, 1'b0, 32'h0, "w_hold3");
    cyc(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0, "w_lat1");
    cyc(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0, "w_lat2");
    cyc(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b1, 32'h0, "w_lat3");
    cyc(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0, "w_lat4");
    cyc(1, 1'b1, 1'b1, B, 32'h0000_BAD0, 4'hF, 1'b0, 1'b0, 32'h0, "w_drop1");
    cyc(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0, "w_drop2");
    cyc(1, 1'b1, 1'b1, B, 32'h0000_BAD0, 4'hF, 1'b0, 1'b0, 32'h0, "w_drop3");
    cyc(1, 1'b1, 1'b1, B, 32'h0000_BAD0, 4'hF, 1'b0, 1'b0, 32'h0, "w_drop4");
    for (int i = 0; i < 5; i++) begin
      cyc(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0, "w_dropidle");
    end
    cyc(1, 1'b1, 1'b0, B, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0, "w_rd1");
    cyc(1, 1'b1, 1'b0, B, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0, "w_rd2");
    cyc(1, 1'b1, 1'b0, B, 32'h0, 4'h0, 1'b1, 1'b0, 32'h0, "w_rd3");
    cyc(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0, "w_rdlat1");
    cyc(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0, "w_rdlat2");
    cyc(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b1, 32'h1234_5678, "w_rdlat3");
    cyc(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0, "w_rdlat4");

    // GntWait=0, RespLatency=4: 8 back-to-back writes then 8 back-to-back reads
    for (int c = 0; c < 22; c++) begin
      cyc(2, c < 16, c < 8, B + 32'(4 * (c % 8)), ldata(c % 8), 4'hF,
          c < 16, (c >= 4) && (c < 20),
          ((c >= 12) && (c < 20)) ? ldata(c - 12) : 32'h0, $sformatf("l_b2b%0d", c));
    end

    // Asynchronous reset with one response on the output and two in flight
    for (int c = 0; c < 4; c++) begin
      cyc(2, 1'b1, 1'b0, B + 32'(4 * (c + 2)), 32'h0, 4'h0, 1'b1, 1'b0, 32'h0, "l_pre");
    end
    cyc(2, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b1, ldata(2), "l_first");
    chk("l_midrv", 32'(rv[2]), 32'h1);
    req[2] = 1'b1; addr[2] = B + 32'h4; we[2] = 1'b0;
    #2;
    rst_ni = 1'b0;
    #1;
    chk("l_async_gnt", 32'(gnt[2]), 32'h0);
    chk("l_async_rvalid", 32'(rv[2]), 32'h0);
    chk("l_async_rdata", rd[2], 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    req[2] = 1'b0;
    rst_ni = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) begin
      cyc(2, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0, "l_post");
    end
    cyc(2, 1'b1, 1'b0, B + 32'h14, 32'h0, 4'h0, 1'b1, 1'b0, 32'h0, "l_keep_rd");
    for (int i = 0; i < 3; i++) begin
      cyc(2, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0, "l_keep_wait");
    end
    cyc(2, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b1, ldata(5), "l_keep");
    cyc(0, 1'b1, 1'b0, B + 32'hC, 32'h0, 4'h0, 1'b1, 1'b0, 32'h0, "m_keep_rd");
    cyc(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b1, mm[3], "m_keep");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/obi_sb_slave.md
OBI_SB_SLAVE -- requirements
Module: obi_sb_slave

Interface
REQ-001 SHALL have parameter BaseAddr, default 32'h1C00_0000, byte address of memory word 0.
REQ-002 SHALL have parameter MemWords, default 1024, number of 32-bit words (power of two, 16..65536).
REQ-003 SHALL have parameter GntWait, default 0, idle cycles before grant (0..3).
REQ-004 SHALL have parameter RespLatency, default 1, cycles from grant edge to rvalid (1..4).
REQ-005 SHALL have port clk_i  in  1  single clock, all state on rising edge.
REQ-006 SHALL have port rst_ni  in  1  reset, asynchronous, active-low.
REQ-007 SHALL have port sb_req_i  in  1  OBI request from debug-module system-bus master.
REQ-008 SHALL have port sb_addr_i  in  32  byte address, bits [1:0] ignored.
REQ-009 SHALL have port sb_we_i  in  1  1 = write, 0 = read.
REQ-010 SHALL have port sb_wdata_i  in  32  write data.
REQ-011 SHALL have port sb_be_i  in  4  byte enables for writes.
REQ-012 SHALL have port sb_gnt_o  out  1  request accepted this cycle.
REQ-013 SHALL have port sb_rvalid_o  out  1  response valid, one pulse per granted request.
REQ-014 SHALL have port sb_rdata_o  out  32  read data, valid with sb_rvalid_o.

Function
REQ-015 SHALL implement grant FSM IDLE / WAIT / GRANT; IDLE->WAIT on sb_req_i when GntWait>0, else sb_gnt_o asserted combinationally in IDLE.
REQ-016 SHALL count WAIT cycles; after GntWait cycles with sb_req_i held, assert sb_gnt_o for one cycle, return to IDLE.
REQ-017 SHALL return WAIT->IDLE without grant if sb_req_i drops (protocol violation tolerated, no side effect).
REQ-018 SHALL treat back-to-back requests with GntWait=0 as one grant per cycle (full throughput).
REQ-019 SHALL compute index = (sb_addr_i - BaseAddr) >> 2; in range iff index < MemWords, 32-bit unsigned arithmetic (addresses below BaseAddr wrap to large and are out of range).
REQ-020 SHALL on a granted in-range write update only bytes with sb_be_i[n]=1 at the grant edge.
REQ-021 SHALL ignore out-of-range writes and sb_be_i=0 writes, still producing a response.
REQ-022 SHALL sample read data at the grant edge, full word regardless of sb_be_i; out-of-range reads return 32'h0.
REQ-023 SHALL carry each grant through a RespLatency-deep shift pipeline (valid bit + data); sb_rvalid_o asserts exactly RespLatency cycles after the grant cycle.
REQ-024 SHALL drive sb_rdata_o = 32'h0 on write responses and when sb_rvalid_o=0.
REQ-025 SHALL deliver responses in grant order; up to RespLatency outstanding, no backpressure on responses.
REQ-026 SHALL give a read granted one cycle after a write to the same word the new data (write-before-read ordering).
REQ-027 SHALL not generate sb_rvalid_o without a prior grant, nor two pulses per grant.

Reset
REQ-028 SHALL on rst_ni=0 immediately force sb_gnt_o=0, sb_rvalid_o=0, sb_rdata_o=0, FSM=IDLE, wait counter=0, pipeline cleared.
REQ-029 SHALL drop in-flight responses on reset mid-operation; no rvalid after deassertion for pre-reset grants.
REQ-030 SHALL not reset memory contents; content after reset undefined, retained if clock runs.

Verification
REQ-031 Write 0xDEADBEEF be=4'hF to BaseAddr+0x10, then read same -> gnt same cycle, rvalid 1 cycle after each grant, read rdata=0xDEADBEEF, write rdata=0.
REQ-032 Prior word 0xDEADBEEF, write 0x11223344 be=4'b0101, read -> 0xDE22BE44.
REQ-033 Read at BaseAddr+4*MemWords and at BaseAddr-4 -> rvalid with rdata=0; writes there leave word 0 unchanged.
REQ-034 GntWait=2, RespLatency=3, req held -> gnt on 3rd req cycle, rvalid 3 cycles after grant; req dropped in WAIT -> no gnt, no rvalid.
REQ-035 GntWait=0, RespLatency=4, 8 back-to-back reads of words 0..7 -> 8 consecutive rvalid pulses, rdata in address order.
REQ-036 Assert rst_ni=0 asynchronously with 2 responses in flight -> outputs 0 within same cycle, no rvalid after release; earlier written data still readable.
